// File: rtl/ct_fspu_wb_buf_if.sv
// FSPU writeback buffer bundle: EX3 result capture, flush, and RF write-port request/grant.
// master = producer/RF side, slave = the buffer.
interface ct_fspu_wb_buf_if #(
   parameter int PREG_W = 7
);
   logic              fspu_forward_r_vld;
   logic [63:0]       fspu_forward_result;
   logic [63:0]       fspu_mfvr_data;
   logic              dp_fspu_ex3_mfvr;
   logic [PREG_W-1:0] dp_fspu_ex3_dst_preg;
   logic              rtu_yy_xx_flush;
   logic              rf_fspu_wb_grant;
   logic              fspu_wb_vld;
   logic [63:0]       fspu_wb_data;
   logic [PREG_W-1:0] fspu_wb_preg;
   logic              fspu_wb_mfvr;
   logic              fspu_wb_stall;
   logic              fspu_wb_ovfl;

   modport master (
      output fspu_forward_r_vld, fspu_forward_result, fspu_mfvr_data,
             dp_fspu_ex3_mfvr, dp_fspu_ex3_dst_preg, rtu_yy_xx_flush, rf_fspu_wb_grant,
      input  fspu_wb_vld, fspu_wb_data, fspu_wb_preg, fspu_wb_mfvr,
             fspu_wb_stall, fspu_wb_ovfl
   );

   modport slave (
      input  fspu_forward_r_vld, fspu_forward_result, fspu_mfvr_data,
             dp_fspu_ex3_mfvr, dp_fspu_ex3_dst_preg, rtu_yy_xx_flush, rf_fspu_wb_grant,
      output fspu_wb_vld, fspu_wb_data, fspu_wb_preg, fspu_wb_mfvr,
             fspu_wb_stall, fspu_wb_ovfl
   );
endinterface

// File: rtl/ct_fspu_wb_buf.sv
// Two-entry in-order writeback buffer between the FSPU EX3 stage and the shared RF write port.
// Holds results until grant, stalls issue ahead of overflow, and flags a sticky overflow.
module ct_fspu_wb_buf #(
   parameter int DEPTH  = 2,
   parameter int PREG_W = 7
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   ct_fspu_wb_buf_if.slave   wb
);

   typedef struct packed {
      logic [63:0]       data;
      logic [PREG_W-1:0] preg;
      logic              mfvr;
   } entry_t;

   entry_t     mem [DEPTH];
   entry_t     push_entry;
   logic       wptr;
   logic       rptr;
   logic [1:0] count;
   logic       stall_q;
   logic       ovfl_q;
   logic       push;
   logic       pop;
   logic       full;
   logic       accept;

   assign push   = wb.fspu_forward_r_vld & ~wb.rtu_yy_xx_flush;
   assign pop    = (count != 2'd0) & wb.rf_fspu_wb_grant;
   assign full   = (count == 2'd2);
   // When full, a push is only taken if the head retires in the same cycle.
   assign accept = push & (~full | pop);

   assign push_entry.data = wb.dp_fspu_ex3_mfvr ? wb.fspu_mfvr_data : wb.fspu_forward_result;
   assign push_entry.preg = wb.dp_fspu_ex3_dst_preg;
   assign push_entry.mfvr = wb.dp_fspu_ex3_mfvr;

   // NOTE: storage is reset as well, so the head outputs read as zero after reset
   // rather than whatever the RAM powered up with.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (accept) begin
         // NOTE: non-blocking, so a full-buffer push+pop overwrites the slot only after
         // the current head has been presented this cycle.
         mem[wptr] <= push_entry;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else if (wb.rtu_yy_xx_flush) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (accept) wptr <= ~wptr;
         if (pop)    rptr <= ~rptr;
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Stall is registered, so it asserts one result early to cover the one still in flight.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         stall_q <= 1'b0;
         ovfl_q  <= 1'b0;
      end else begin
         stall_q <= full | ((count == 2'd1) & push & ~pop);
         if (push & full & ~pop) ovfl_q <= 1'b1;
      end
   end

   assign wb.fspu_wb_vld   = (count != 2'd0);
   assign wb.fspu_wb_data  = mem[rptr].data;
   assign wb.fspu_wb_preg  = mem[rptr].preg;
   assign wb.fspu_wb_mfvr  = mem[rptr].mfvr;
   assign wb.fspu_wb_stall = stall_q;
   assign wb.fspu_wb_ovfl  = ovfl_q;

endmodule

// File: tb/tb_ct_fspu_wb_buf.sv
// Scoreboard bench for ct_fspu_wb_buf: directed pushes enqueue expected entries,
// a negedge monitor pops and compares each granted writeback.
module tb_ct_fspu_wb_buf;

   typedef struct {
      logic [63:0] data;
      logic [6:0]  preg;
      logic        mfvr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   ct_fspu_wb_buf_if #(.PREG_W(7)) bus ();

   ct_fspu_wb_buf #(.DEPTH(2), .PREG_W(7)) dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .wb             (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] fwd, input logic [63:0] mv, input logic mfvr,
                       input logic [6:0] preg, input logic grant,
                       input logic [63:0] exp_data, input logic enq);
      exp_t e;
      bus.fspu_forward_r_vld   = 1'b1;
      bus.fspu_forward_result  = fwd;
      bus.fspu_mfvr_data       = mv;
      bus.dp_fspu_ex3_mfvr     = mfvr;
      bus.dp_fspu_ex3_dst_preg = preg;
      bus.rf_fspu_wb_grant     = grant;
      if (enq) begin
         e.data = exp_data;
         e.preg = preg;
         e.mfvr = mfvr;
         q.push_back(e);
      end
      step();
      bus.fspu_forward_r_vld = 1'b0;
   endtask

   task automatic idle(input logic grant, input int n);
      bus.fspu_forward_r_vld = 1'b0;
      bus.rf_fspu_wb_grant   = grant;
      for (int i = 0; i < n; i++) step();
   endtask

   // Monitor: a granted head retires at the next rising edge, so compare it here.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.fspu_wb_vld) begin
         if (q.size() == 0) begin
            check("spurious_wb_vld", 64'(bus.fspu_wb_vld), 64'd0);
         end else if (bus.rf_fspu_wb_grant) begin
            e = q.pop_front();
            check("wb_data", bus.fspu_wb_data, e.data);
            check("wb_preg", 64'(bus.fspu_wb_preg), 64'(e.preg));
            check("wb_mfvr", 64'(bus.fspu_wb_mfvr), 64'(e.mfvr));
         end
      end
   end

   initial begin
      bus.fspu_forward_r_vld   = 1'b0;
      bus.fspu_forward_result  = '0;
      bus.fspu_mfvr_data       = '0;
      bus.dp_fspu_ex3_mfvr     = 1'b0;
      bus.dp_fspu_ex3_dst_preg = '0;
      bus.rtu_yy_xx_flush      = 1'b0;
      bus.rf_fspu_wb_grant     = 1'b0;

      #1 rst = 1'b1;
      #2;
      check("rst_vld",   64'(bus.fspu_wb_vld),   64'd0);
      check("rst_data",  bus.fspu_wb_data,       64'd0);
      check("rst_preg",  64'(bus.fspu_wb_preg),  64'd0);
      check("rst_mfvr",  64'(bus.fspu_wb_mfvr),  64'd0);
      check("rst_stall", 64'(bus.fspu_wb_stall), 64'd0);
      check("rst_ovfl",  64'(bus.fspu_wb_ovfl),  64'd0);
      #10 rst = 1'b0;
      step();

      // Single push, grant held high: one-cycle residency.
      push(64'h1111, 64'h0, 1'b0, 7'd5, 1'b1, 64'h1111, 1'b1);
      check("single_vld_up", 64'(bus.fspu_wb_vld), 64'd1);
      idle(1'b1, 1);
      check("single_vld_down", 64'(bus.fspu_wb_vld), 64'd0);

      // Integer destination selects the move-from-vector data.
      push(64'hAAAA, 64'h5555, 1'b1, 7'd7, 1'b1, 64'h5555, 1'b1);
      idle(1'b1, 1);
      check("mfvr_vld_down", 64'(bus.fspu_wb_vld), 64'd0);

      // Fill to two, then drain in order; repeated to wrap the pointers.
      for (int r = 0; r < 3; r++) begin
         push(64'h100 + 64'(r), 64'h0, 1'b0, 7'd1, 1'b0, 64'h100 + 64'(r), 1'b1);
         push(64'h200 + 64'(r), 64'h0, 1'b0, 7'd2, 1'b0, 64'h200 + 64'(r), 1'b1);
         check("fill_stall", 64'(bus.fspu_wb_stall), 64'd1);
         check("fill_head_preg", 64'(bus.fspu_wb_preg), 64'd1);
         idle(1'b1, 2);
         check("drain_vld", 64'(bus.fspu_wb_vld), 64'd0);
         check("drain_stall", 64'(bus.fspu_wb_stall), 64'd0);
      end

      // Push and pop together while full: freed slot is reused, order kept.
      push(64'h301, 64'h0, 1'b0, 7'd1, 1'b0, 64'h301, 1'b1);
      push(64'h302, 64'h0, 1'b0, 7'd2, 1'b0, 64'h302, 1'b1);
      push(64'h303, 64'h0, 1'b0, 7'd3, 1'b1, 64'h303, 1'b1);
      check("pp_stall", 64'(bus.fspu_wb_stall), 64'd1);
      check("pp_head_preg", 64'(bus.fspu_wb_preg), 64'd2);
      idle(1'b1, 2);
      check("pp_vld", 64'(bus.fspu_wb_vld), 64'd0);

      // Overflow: third push without grant is dropped and the flag sticks.
      check("ovfl_before", 64'(bus.fspu_wb_ovfl), 64'd0);
      push(64'h401, 64'h0, 1'b0, 7'd1, 1'b0, 64'h401, 1'b1);
      push(64'h402, 64'h0, 1'b0, 7'd2, 1'b0, 64'h402, 1'b1);
      push(64'h909, 64'h0, 1'b0, 7'd9, 1'b0, 64'h909, 1'b0);
      check("ovfl_set", 64'(bus.fspu_wb_ovfl), 64'd1);
      check("ovfl_head_data", bus.fspu_wb_data, 64'h401);
      idle(1'b1, 2);
      check("ovfl_drained", 64'(bus.fspu_wb_vld), 64'd0);
      idle(1'b0, 3);
      check("ovfl_sticky", 64'(bus.fspu_wb_ovfl), 64'd1);

      // Flush wins over a same-cycle push and empties the buffer.
      push(64'h504, 64'h0, 1'b0, 7'd4, 1'b0, 64'h504, 1'b1);
      bus.rtu_yy_xx_flush = 1'b1;
      push(64'h505, 64'h0, 1'b0, 7'd5, 1'b0, 64'h505, 1'b0);
      bus.rtu_yy_xx_flush = 1'b0;
      q.delete();
      check("flush_vld", 64'(bus.fspu_wb_vld), 64'd0);
      check("flush_ovfl_kept", 64'(bus.fspu_wb_ovfl), 64'd1);

      // Reset between edges with one entry held: outputs clear immediately.
      push(64'h606, 64'h0, 1'b0, 7'd6, 1'b0, 64'h606, 1'b1);
      check("arst_pre_vld", 64'(bus.fspu_wb_vld), 64'd1);
      #1 rst = 1'b1;
      q.delete();
      #1;
      check("arst_vld",   64'(bus.fspu_wb_vld),   64'd0);
      check("arst_data",  bus.fspu_wb_data,       64'd0);
      check("arst_ovfl",  64'(bus.fspu_wb_ovfl),  64'd0);
      check("arst_stall", 64'(bus.fspu_wb_stall), 64'd0);
      #1 rst = 1'b0;
      step();

      // Buffer works normally after the mid-run reset.
      push(64'h777, 64'h888, 1'b1, 7'd3, 1'b1, 64'h888, 1'b1);
      idle(1'b1, 1);
      check("post_rst_vld", 64'(bus.fspu_wb_vld), 64'd0);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ct_fspu_wb_buf.md
# ct_fspu_wb_buf

Two-entry in-order writeback buffer directly downstream of the FSPU execution pipe in the VFALU. It captures each valid FSPU result at EX3 (the forward result for FP/vector destinations, the move-from-vector data for integer destinations), tags it with its destination, and holds it until the shared register-file write port grants. It also raises a stall toward issue before the buffer can overflow, and latches a sticky error if an overflow occurs anyway.

## Interface
Parameters:
- DEPTH, 2, number of entries; fixed at 2 (pointers are 1 bit)
- PREG_W, 7, physical register tag width

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, asynchronous, active-high
- fspu_forward_r_vld  in  1  FSPU result valid at EX3 (push)
- fspu_forward_result  in  64  FP/vector result data
- fspu_mfvr_data  in  64  move-from-vector result data
- dp_fspu_ex3_mfvr  in  1  1: destination is integer RF (use mfvr data); 0: FP/vector RF
- dp_fspu_ex3_dst_preg  in  PREG_W  destination physical register
- rtu_yy_xx_flush  in  1  pipeline flush; empties the buffer
- rf_fspu_wb_grant  in  1  write port accepts the head entry this cycle
- fspu_wb_vld  out  1  head entry valid (write request)
- fspu_wb_data  out  64  head data
- fspu_wb_preg  out  PREG_W  head destination
- fspu_wb_mfvr  out  1  head destination type
- fspu_wb_stall  out  1  stop issuing to FSPU
- fspu_wb_ovfl  out  1  sticky overflow error

## Operation
- Storage: 2 entries of {data[63:0], preg, mfvr}, write pointer wptr, read pointer rptr (1 bit each), count[1:0] (range 0..2).
- push = fspu_forward_r_vld & ~rtu_yy_xx_flush.
- Push data = dp_fspu_ex3_mfvr ? fspu_mfvr_data : fspu_forward_result, written at entry[wptr]; wptr toggles on every accepted push.
- pop = fspu_wb_vld & rf_fspu_wb_grant; rptr toggles on pop.
- fspu_wb_vld = (count != 0); the head fields come from entry[rptr] and are driven straight from storage.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together.
- Full (count==2):
  - push with pop: accepted; the freed slot is reused.
  - push without pop: the entry is dropped, nothing in storage or the pointers changes, and fspu_wb_ovfl is set.
- fspu_wb_ovfl stays set until cpurst.
- fspu_wb_stall = (count==2) | (count==1 & push & ~pop). Registered, and covers the one result that may still be in flight.
- Flush has priority over push and pop in the same cycle:
  - count, wptr, rptr clear to 0.
  - fspu_wb_vld is 0 on the next cycle.
  - fspu_wb_ovfl is unaffected.
- Writeback order equals push order; no bypassing and no reordering.

## Timing
- Reset (asynchronous, active-high, on cpurst rising):
  - fspu_wb_vld=0, fspu_wb_data=0, fspu_wb_preg=0, fspu_wb_mfvr=0
  - fspu_wb_stall=0, fspu_wb_ovfl=0
  - count=0, wptr=0, rptr=0; entry storage also cleared to 0.
- Reset asserted mid-operation: all entries are discarded immediately, without waiting for a clock edge.
- Latency: push at edge N gives fspu_wb_vld=1 in cycle N+1. Minimum residency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when grant is held high.
- Grant while fspu_wb_vld=0 is ignored.
- Head outputs stay stable while fspu_wb_vld=1 and grant=0.
- fspu_wb_stall is a flop output. It is valid in the cycle after the condition that sets it, and deasserts in the cycle after the count drops to 0 or 1 with no push.

## Test plan
- Reset then single push: push {fwd=64'h1111, preg=5, mfvr=0} with grant held 1. Expected: fspu_wb_vld=1 for exactly one cycle with data 64'h1111 and preg 5; count returns to 0.
- Mfvr select: push with mfvr=1, fwd=64'hAAAA, mfvr_data=64'h5555. Expected: fspu_wb_data=64'h5555 and fspu_wb_mfvr=1.
- Fill and drain with wrap: grant=0, push preg 1 then preg 2. Expected: stall rises and count=2. Then grant=1 for 2 cycles. Expected: preg 1 then preg 2 in order, stall clears. Repeat 3 times to exercise pointer wrap.
- Simultaneous push and pop at full: count=2, push preg 3 with grant=1. Expected: head preg 1 retires, count stays 2, and the order 2, 3 drains next.
- Overflow: count=2, grant=0, push preg 9. Expected: entry dropped, fspu_wb_ovfl=1 and still 1 after later drains; only cpurst clears it.
- Flush vs push plus async reset: flush in the same cycle as a push. Expected: fspu_wb_vld=0 next cycle. Then cpurst asserted between clock edges with count=1. Expected: fspu_wb_vld drops immediately.
